// File: rtl/csm_shared_mem.sv
// csm_shared_mem: dual-port shared memory with per-port command FSMs and one exclusive lock.
// Optional lock watchdog is built when CSM_LOCK_TIMEOUT_EN is defined.
module csm_shared_mem #(
    parameter int DATABITS     = 8,
    parameter int ERRBITS      = 2,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATABITS-1:0] A_in_AD,
    input  logic                A_rw,
    input  logic                A_enable,
    input  logic                A_hold,
    input  logic                A_release,
    output logic                A_ack,
    output logic [ERRBITS-1:0]  A_err,
    output logic [DATABITS-1:0] A_out_data,
    input  logic [DATABITS-1:0] B_in_AD,
    input  logic                B_rw,
    input  logic                B_enable,
    input  logic                B_hold,
    input  logic                B_release,
    output logic                B_ack,
    output logic [ERRBITS-1:0]  B_err,
    output logic [DATABITS-1:0] B_out_data
);

    typedef enum logic {S_IDLE, S_WDATA} state_t;

    localparam int DEPTH = 2 ** DATABITS;
    localparam logic [ERRBITS-1:0] ERR_OK        = ERRBITS'(0);
    localparam logic [ERRBITS-1:0] ERR_LOCKED    = ERRBITS'(1);
    localparam logic [ERRBITS-1:0] ERR_NOT_OWNER = ERRBITS'(2);
    localparam logic [ERRBITS-1:0] ERR_COLLISION = ERRBITS'(3);

    logic [DATABITS-1:0] r_mem [DEPTH];
    state_t              r_state [2];
    logic [DATABITS-1:0] r_addr [2];
    logic [1:0]          r_ack;
    logic [ERRBITS-1:0]  r_err [2];
    logic [DATABITS-1:0] r_outData [2];
    logic                r_lockOwned;
    logic                r_lockOwner;

    logic [DATABITS-1:0] w_ad [2];
    logic [1:0] w_en, w_rw, w_hold, w_rel;
    logic [1:0] w_cmd, w_isHold, w_isRel, w_isWrite, w_isRead, w_isData;
    logic [1:0] w_otherOwns, w_wrOk, w_holdOk, w_relOk;
    logic       w_collide, w_nextOwned, w_nextOwner;

    assign w_ad[0] = A_in_AD;
    assign w_ad[1] = B_in_AD;
    assign w_en    = {B_enable, A_enable};
    assign w_rw    = {B_rw, A_rw};
    assign w_hold  = {B_hold, A_hold};
    assign w_rel   = {B_release, A_release};

    // Decode with priority hold > release > write > read; data phase ignores enable.
    always_comb begin
        w_cmd = '0; w_isHold = '0; w_isRel = '0; w_isWrite = '0;
        w_isRead = '0; w_isData = '0; w_otherOwns = '0; w_wrOk = '0;
        for (int p = 0; p < 2; p++) begin
            w_cmd[p]       = (r_state[p] == S_IDLE) && w_en[p];
            w_isHold[p]    = w_cmd[p] && w_hold[p];
            w_isRel[p]     = w_cmd[p] && !w_hold[p] && w_rel[p];
            w_isWrite[p]   = w_cmd[p] && !w_hold[p] && !w_rel[p] && w_rw[p];
            w_isRead[p]    = w_cmd[p] && !w_hold[p] && !w_rel[p] && !w_rw[p];
            w_isData[p]    = (r_state[p] == S_WDATA);
            w_otherOwns[p] = r_lockOwned && (r_lockOwner != 1'(p));
            w_wrOk[p]      = w_isData[p] && !w_otherOwns[p];
        end
    end

    assign w_collide = w_wrOk[0] && w_wrOk[1] && (r_addr[0] == r_addr[1]);

    // Releases are resolved before holds so a same-cycle handover succeeds; A wins hold ties.
    always_comb begin
        w_relOk     = '0;
        w_holdOk    = '0;
        w_nextOwned = r_lockOwned;
        w_nextOwner = r_lockOwner;
        for (int p = 0; p < 2; p++) begin
            if (w_isRel[p] && w_nextOwned && (w_nextOwner == 1'(p))) begin
                w_nextOwned = 1'b0;
                w_relOk[p]  = 1'b1;
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (w_isHold[p] && (!w_nextOwned || (w_nextOwner == 1'(p)))) begin
                w_nextOwned = 1'b1;
                w_nextOwner = 1'(p);
                w_holdOk[p] = 1'b1;
            end
        end
    end

`ifdef CSM_LOCK_TIMEOUT_EN
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    logic [TW-1:0] r_timer;
    logic          w_ownerCmd;

    assign w_ownerCmd = r_lockOwned && w_cmd[r_lockOwner];

    // Watchdog frees a lock whose owner has issued no command for LOCK_TIMEOUT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lockOwned <= 1'b0;
            r_lockOwner <= 1'b0;
            r_timer     <= '0;
        end else begin
            r_lockOwner <= w_nextOwner;
            if ((|w_holdOk) || w_ownerCmd || !w_nextOwned) begin
                r_lockOwned <= w_nextOwned;
                r_timer     <= '0;
            end else if (r_timer == TW'(LOCK_TIMEOUT - 1)) begin
                r_lockOwned <= 1'b0;
                r_timer     <= '0;
            end else begin
                r_lockOwned <= w_nextOwned;
                r_timer     <= r_timer + TW'(1);
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lockOwned <= 1'b0;
            r_lockOwner <= 1'b0;
        end else begin
            r_lockOwned <= w_nextOwned;
            r_lockOwner <= w_nextOwner;
        end
    end
`endif

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (reset) begin
                r_state[p]   <= S_IDLE;
                r_ack[p]     <= 1'b0;
                r_err[p]     <= ERR_OK;
                r_outData[p] <= '0;
                r_addr[p]    <= '0;
            end else if (w_isData[p]) begin
                r_state[p] <= S_IDLE;
                r_ack[p]   <= 1'b1;
                if (w_otherOwns[p])
                    r_err[p] <= ERR_LOCKED;
                else if ((p == 1) && w_collide)
                    r_err[p] <= ERR_COLLISION;
                else
                    r_err[p] <= ERR_OK;
            end else begin
                r_ack[p] <= 1'b1;
                if (w_isWrite[p]) begin
                    r_addr[p]  <= w_ad[p];
                    r_state[p] <= S_WDATA;
                    r_ack[p]   <= 1'b0;
                end else if (w_isHold[p]) begin
                    r_err[p] <= w_holdOk[p] ? ERR_OK : ERR_LOCKED;
                end else if (w_isRel[p]) begin
                    r_err[p] <= w_relOk[p] ? ERR_OK : ERR_NOT_OWNER;
                end else if (w_isRead[p]) begin
                    if (w_otherOwns[p]) begin
                        r_outData[p] <= '0;
                        r_err[p]     <= ERR_LOCKED;
                    end else begin
                        r_outData[p] <= r_mem[w_ad[p]];
                        r_err[p]     <= ERR_OK;
                    end
                end
            end
        end
    end

    // Port A takes precedence on a same-address write; reset aborts any data phase.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_wrOk[0])
                r_mem[r_addr[0]] <= w_ad[0];
            if (w_wrOk[1] && !w_collide)
                r_mem[r_addr[1]] <= w_ad[1];
        end
    end

    assign A_ack      = r_ack[0];
    assign B_ack      = r_ack[1];
    assign A_err      = r_err[0];
    assign B_err      = r_err[1];
    assign A_out_data = r_outData[0];
    assign B_out_data = r_outData[1];

endmodule

// File: tb/tb_csm_shared_mem.sv
// tb_csm_shared_mem: directed and random checks of csm_shared_mem against a cycle-level reference model.
// Watchdog checks are included when CSM_LOCK_TIMEOUT_EN is defined (LOCK_TIMEOUT=8).
module tb_csm_shared_mem;

    localparam int LT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] inAD [2];
    logic [1:0] rw, en, hold, rel;
    logic       aAck, bAck;
    logic [1:0] aErr, bErr;
    logic [7:0] aOut, bOut;

    // Reference model state
    logic [7:0] mMem [256];
    bit         mOwned;
    int         mOwner;
    int         mIdle;
    bit         mPend [2];
    logic [7:0] mAddr [2];
    logic [1:0] expAck;
    logic [1:0] expErr [2];
    logic [7:0] expOut [2];

    int total = 0;
    int bad   = 0;

    csm_shared_mem #(.DATABITS(8), .ERRBITS(2), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .reset(reset),
        .A_in_AD(inAD[0]), .A_rw(rw[0]), .A_enable(en[0]), .A_hold(hold[0]), .A_release(rel[0]),
        .A_ack(aAck), .A_err(aErr), .A_out_data(aOut),
        .B_in_AD(inAD[1]), .B_rw(rw[1]), .B_enable(en[1]), .B_hold(hold[1]), .B_release(rel[1]),
        .B_ack(bAck), .B_err(bErr), .B_out_data(bOut)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fillVal(input int a);
        return 8'(a * 7 + 3);
    endfunction

    // One clock of behaviour computed from the bus rules
    task automatic modelStep(input bit rst);
        bit cmd [2];
        bit blocked [2];
        bit doWrite [2];
        bit preOwned, ownerActive, acquired, sameAddr;
        int preOwner;
        if (rst) begin
            mOwned = 0; mOwner = 0; mIdle = 0;
            for (int p = 0; p < 2; p++) begin
                mPend[p] = 0; expAck[p] = 1'b0; expErr[p] = 2'b00; expOut[p] = 8'h00;
            end
            return;
        end
        preOwned = mOwned; preOwner = mOwner;
        for (int p = 0; p < 2; p++) begin
            cmd[p]     = !mPend[p] && en[p];
            blocked[p] = preOwned && (preOwner != p);
            doWrite[p] = mPend[p] && !blocked[p];
        end
        sameAddr = doWrite[0] && doWrite[1] && (mAddr[0] == mAddr[1]);
        for (int p = 0; p < 2; p++) begin
            if (mPend[p])
                expErr[p] = blocked[p] ? 2'b01 : ((p == 1 && sameAddr) ? 2'b11 : 2'b00);
            if (cmd[p] && !hold[p] && !rel[p] && !rw[p]) begin
                expOut[p] = blocked[p] ? 8'h00 : mMem[inAD[p]];
                expErr[p] = blocked[p] ? 2'b01 : 2'b00;
            end
        end
        ownerActive = preOwned && cmd[preOwner];
        if (doWrite[1] && !sameAddr) mMem[mAddr[1]] = inAD[1];
        if (doWrite[0]) mMem[mAddr[0]] = inAD[0];
        for (int p = 0; p < 2; p++)
            if (cmd[p] && !hold[p] && rel[p]) begin
                if (mOwned && mOwner == p) begin mOwned = 0; expErr[p] = 2'b00; end
                else expErr[p] = 2'b10;
            end
        acquired = 0;
        for (int p = 0; p < 2; p++)
            if (cmd[p] && hold[p]) begin
                if (!mOwned || mOwner == p) begin
                    mOwned = 1; mOwner = p; expErr[p] = 2'b00; acquired = 1;
                end else expErr[p] = 2'b01;
            end
`ifdef CSM_LOCK_TIMEOUT_EN
        if (acquired || ownerActive || !mOwned) mIdle = 0;
        else begin
            mIdle++;
            if (mIdle >= LT) begin mOwned = 0; mIdle = 0; end
        end
`endif
        for (int p = 0; p < 2; p++) begin
            if (mPend[p]) mPend[p] = 0;
            else if (cmd[p] && !hold[p] && !rel[p] && rw[p]) begin
                mPend[p] = 1; mAddr[p] = inAD[p];
            end
            expAck[p] = !mPend[p];
        end
    endtask

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        checkVal("A_ack", {7'd0, aAck}, {7'd0, expAck[0]});
        checkVal("B_ack", {7'd0, bAck}, {7'd0, expAck[1]});
        checkVal("A_err", {6'd0, aErr}, {6'd0, expErr[0]});
        checkVal("B_err", {6'd0, bErr}, {6'd0, expErr[1]});
        checkVal("A_out", aOut, expOut[0]);
        checkVal("B_out", bOut, expOut[1]);
    endtask

    task automatic applyStimulus(input bit rst);
        reset = rst;
        modelStep(rst);
        @(posedge clk);
        #1;
        checkOutput();
        en = '0; hold = '0; rel = '0; rw = '0;
    endtask

    task automatic cmd(input int p, input bit w, input bit h, input bit r, input logic [7:0] ad);
        en[p] = 1'b1; rw[p] = w; hold[p] = h; rel[p] = r; inAD[p] = ad;
    endtask

    initial begin
        int k;
        logic [7:0] a;
        en = '0; hold = '0; rel = '0; rw = '0;
        inAD[0] = 8'h00; inAD[1] = 8'h00;
        applyStimulus(1);
        applyStimulus(1);
        checkVal("reset_A_ack", {7'd0, aAck}, 8'h00);
        applyStimulus(0);
        checkVal("ack_after_reset", {7'd0, aAck}, 8'h01);

        // Known contents everywhere, A fills the low half while B fills the high half
        for (int i = 0; i < 128; i++) begin
            cmd(0, 1, 0, 0, 8'(i));
            cmd(1, 1, 0, 0, 8'(i + 128));
            applyStimulus(0);
            inAD[0] = fillVal(i);
            inAD[1] = fillVal(i + 128);
            applyStimulus(0);
        end

        $display("[TB] basic write/read");
        cmd(0, 1, 0, 0, 8'h10); applyStimulus(0);
        checkVal("A_ack_wdata", {7'd0, aAck}, 8'h00);
        inAD[0] = 8'hA5; applyStimulus(0);
        checkVal("A_ack_back", {7'd0, aAck}, 8'h01);
        cmd(0, 0, 0, 0, 8'h10); applyStimulus(0);
        checkVal("A_rd_0x10", aOut, 8'hA5);
        checkVal("A_rd_err", {6'd0, aErr}, 8'h00);

        $display("[TB] lock blocks other port");
        cmd(0, 0, 1, 0, 8'h00); applyStimulus(0);
        cmd(1, 1, 0, 0, 8'h20); applyStimulus(0);
        inAD[1] = 8'h11; applyStimulus(0);
        checkVal("B_wr_locked", {6'd0, bErr}, 8'h01);
        cmd(1, 0, 0, 0, 8'h20); applyStimulus(0);
        checkVal("B_rd_locked_err", {6'd0, bErr}, 8'h01);
        checkVal("B_rd_locked_data", bOut, 8'h00);
        cmd(0, 0, 0, 1, 8'h00); applyStimulus(0);
        cmd(1, 0, 0, 0, 8'h20); applyStimulus(0);
        checkVal("B_rd_free_err", {6'd0, bErr}, 8'h00);
        checkVal("B_rd_0x20_kept", bOut, fillVal(8'h20));

        $display("[TB] write collision");
        cmd(0, 1, 0, 0, 8'h30); cmd(1, 1, 0, 0, 8'h30); applyStimulus(0);
        inAD[0] = 8'h01; inAD[1] = 8'h02; applyStimulus(0);
        checkVal("coll_A_err", {6'd0, aErr}, 8'h00);
        checkVal("coll_B_err", {6'd0, bErr}, 8'h03);
        cmd(0, 0, 0, 0, 8'h30); applyStimulus(0);
        checkVal("coll_rd", aOut, 8'h01);

        $display("[TB] simultaneous hold and handover");
        cmd(0, 0, 1, 0, 8'h00); cmd(1, 0, 1, 0, 8'h00); applyStimulus(0);
        checkVal("hold_A_err", {6'd0, aErr}, 8'h00);
        checkVal("hold_B_err", {6'd0, bErr}, 8'h01);
        cmd(1, 0, 0, 1, 8'h00); applyStimulus(0);
        checkVal("B_rel_notowner", {6'd0, bErr}, 8'h02);
        cmd(1, 0, 0, 0, 8'h30); applyStimulus(0);
        checkVal("B_rd_still_locked", {6'd0, bErr}, 8'h01);
        cmd(0, 0, 0, 1, 8'h00); cmd(1, 0, 1, 0, 8'h00); applyStimulus(0);
        checkVal("handover_A", {6'd0, aErr}, 8'h00);
        checkVal("handover_B", {6'd0, bErr}, 8'h00);
        cmd(0, 0, 0, 0, 8'h30); applyStimulus(0);
        checkVal("A_rd_after_handover", {6'd0, aErr}, 8'h01);
        cmd(1, 0, 0, 1, 8'h00); applyStimulus(0);

        $display("[TB] read during write to same address");
        cmd(0, 1, 0, 0, 8'h50); applyStimulus(0);
        inAD[0] = 8'h77; cmd(1, 0, 0, 0, 8'h50); applyStimulus(0);
        checkVal("rd_pre_write", bOut, fillVal(8'h50));
        cmd(1, 0, 0, 0, 8'h50); applyStimulus(0);
        checkVal("rd_post_write", bOut, 8'h77);

        $display("[TB] reset during data phase");
        cmd(0, 1, 0, 0, 8'h40); applyStimulus(0);
        inAD[0] = 8'hEE; applyStimulus(1);
        checkVal("ack_in_reset", {7'd0, aAck}, 8'h00);
        applyStimulus(1);
        applyStimulus(0);
        checkVal("ack_post_reset", {7'd0, aAck}, 8'h01);
        cmd(0, 0, 0, 0, 8'h40); applyStimulus(0);
        checkVal("rd_0x40_kept", aOut, fillVal(8'h40));

`ifdef CSM_LOCK_TIMEOUT_EN
        $display("[TB] lock watchdog");
        cmd(0, 0, 1, 0, 8'h00); applyStimulus(0);
        repeat (LT) applyStimulus(0);
        cmd(1, 0, 0, 0, 8'h40); applyStimulus(0);
        checkVal("wd_B_rd_err", {6'd0, bErr}, 8'h00);
        cmd(0, 0, 0, 1, 8'h00); applyStimulus(0);
        checkVal("wd_A_rel_err", {6'd0, aErr}, 8'h02);
`endif

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (mPend[p]) begin
                    inAD[p] = 8'($urandom);
                    en[p]   = 1'($urandom);
                end else if ($urandom_range(0, 3) != 0) begin
                    k = $urandom_range(0, 15);
                    a = ($urandom_range(0, 1) == 1) ? 8'(8'h30 + $urandom_range(0, 3)) : 8'($urandom);
                    if (k == 0)      cmd(p, 0, 1, 0, a);
                    else if (k == 1) cmd(p, 0, 0, 1, a);
                    else if (k < 8)  cmd(p, 1, 0, 0, a);
                    else             cmd(p, 0, 0, 0, a);
                end
            end
            applyStimulus($urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
